// File: rtl/load_counter.sv
// Loadable up/down counter for the gate-level datapath library.
// Next-state selection is built from mux2 cells (step-vs-hold, then
// load-vs-result) feeding a flop bank; only the control decode is behavioural.

// Single-bit 2:1 multiplexer cell: y = s ? b : a.
module mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule

module load_counter #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             wrap,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             ovf
);

  logic [WIDTH-1:0] delta;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] run_val;
  logic [WIDTH-1:0] next_count;
  logic             at_term;
  logic             sel_step;
  logic             ovf_next;

  // Adding all-ones is a decrement modulo 2^WIDTH, so one adder covers both
  // directions. The natural carry-out/borrow of that adder already produces
  // the wrapped value at the terminal count.
  assign delta    = {{(WIDTH-1){~up}}, 1'b1};
  assign step_val = count + delta;

  // Terminal value is all-ones counting up, zero counting down.
  assign at_term  = up ? (count == '1) : (count == '0);

  // Saturation is expressed by steering the first mux onto the hold path.
  assign sel_step = en & ~(at_term & ~wrap);

  // Boundary event: an enabled, non-load step taken from the terminal value.
  assign ovf_next = ~load & en & at_term;

  // Per-bit mux2 cells: stepped value vs. hold, then load vs. that result.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux2 u_step_mux (
      .a (count[i]),
      .b (step_val[i]),
      .s (sel_step),
      .y (run_val[i])
    );

    mux2 u_load_mux (
      .a (run_val[i]),
      .b (load_val[i]),
      .s (load),
      .y (next_count[i])
    );
  end

  // Flop bank for the count and the one-cycle boundary pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RESET_VAL;
      ovf   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, as real flops do.
      count <= next_count;
      ovf   <= ovf_next;
    end
  end

  assign zero = (count == '0);

endmodule

// File: tb/tb_load_counter.sv
// Directed and random checks of load_counter (WIDTH = 4) against a
// behavioural reference model; a second instance checks a non-zero RESET_VAL.
`timescale 1ns/1ps

module tb_load_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic         up;
  logic         wrap;
  logic [W-1:0] count;
  logic         zero;
  logic         ovf;
  logic [W-1:0] count5;
  logic         zero5;
  logic         ovf5;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_count;
  logic         m_ovf;
  logic         term;

  always #5 clk = ~clk;

  load_counter #(.WIDTH(W), .RESET_VAL(4'd0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .up       (up),
    .wrap     (wrap),
    .count    (count),
    .zero     (zero),
    .ovf      (ovf)
  );

  load_counter #(.WIDTH(W), .RESET_VAL(4'd5)) dut5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .up       (up),
    .wrap     (wrap),
    .count    (count5),
    .zero     (zero5),
    .ovf      (ovf5)
  );

  task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [W-1:0] c, input logic o);
    check({tag, ".count"}, 8'(count), 8'(c));
    check({tag, ".zero"},  8'(zero),  8'(c == 0));
    check({tag, ".ovf"},   8'(ovf),   8'(o));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; up = 1'b1; wrap = 1'b1;

    // Reset state of both instances.
    #12;
    expect_state("por", 4'd0, 1'b0);
    check("por5.count", 8'(count5), 8'd5);
    check("por5.zero",  8'(zero5),  8'd0);
    rst_n = 1'b1;

    // Load 7, then assert reset mid-cycle: clears before the next edge.
    load = 1'b1; load_val = 4'd7;
    tick();
    expect_state("load7", 4'd7, 1'b0);
    load = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    expect_state("midrst", 4'd0, 1'b0);
    check("midrst5.count", 8'(count5), 8'd5);
    check("midrst5.zero",  8'(zero5),  8'd0);
    #2 rst_n = 1'b1;

    // Up wrap: 14, 15, 0, 1 with ovf only at 0.
    load = 1'b1; load_val = 4'd14;
    tick();
    expect_state("upw.0", 4'd14, 1'b0);
    load = 1'b0; en = 1'b1; up = 1'b1; wrap = 1'b1;
    tick(); expect_state("upw.1", 4'd15, 1'b0);
    tick(); expect_state("upw.2", 4'd0,  1'b1);
    tick(); expect_state("upw.3", 4'd1,  1'b0);

    // Down saturate: 1, 0, 0, 0, 0 with ovf 0, 1, 1, 1.
    en = 1'b0; load = 1'b1; load_val = 4'd1;
    tick(); expect_state("dns.0", 4'd1, 1'b0);
    load = 1'b0; en = 1'b1; up = 1'b0; wrap = 1'b0;
    tick(); expect_state("dns.1", 4'd0, 1'b0);
    tick(); expect_state("dns.2", 4'd0, 1'b1);
    tick(); expect_state("dns.3", 4'd0, 1'b1);
    tick(); expect_state("dns.4", 4'd0, 1'b1);

    // Load priority over an enabled step from the terminal value.
    en = 1'b0; load = 1'b1; load_val = 4'd15;
    tick(); expect_state("lp.0", 4'd15, 1'b0);
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd3;
    tick(); expect_state("lp.1", 4'd3, 1'b0);
    load = 1'b0;
    tick(); expect_state("lp.2", 4'd4, 1'b0);

    // Hold with en low while up/wrap toggle.
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up = i[0]; wrap = ~i[0];
      tick(); expect_state("hold", 4'd4, 1'b0);
    end

    // Up saturate holds at 15 with ovf; down wrap from 0 goes to 15.
    load = 1'b1; load_val = 4'd15;
    tick(); expect_state("ups.0", 4'd15, 1'b0);
    load = 1'b0; en = 1'b1; up = 1'b1; wrap = 1'b0;
    tick(); expect_state("ups.1", 4'd15, 1'b1);
    en = 1'b0; load = 1'b1; load_val = 4'd0;
    tick(); expect_state("dnw.0", 4'd0, 1'b0);
    load = 1'b0; en = 1'b1; up = 1'b0; wrap = 1'b1;
    tick(); expect_state("dnw.1", 4'd15, 1'b1);
    tick(); expect_state("dnw.2", 4'd14, 1'b0);

    // Random regression against the reference model; the first cycle loads
    // so the model starts in a known state.
    m_count = '0;
    m_ovf   = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      load     = (i == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up       = 1'($urandom);
      wrap     = 1'($urandom);
      load_val = 4'($urandom);
      if (load) begin
        m_count = load_val;
        m_ovf   = 1'b0;
      end else if (en) begin
        term = up ? (m_count == 4'd15) : (m_count == 4'd0);
        if (term) begin
          m_ovf = 1'b1;
          if (wrap) m_count = up ? 4'd0 : 4'd15;
        end else begin
          m_ovf   = 1'b0;
          m_count = up ? m_count + 4'd1 : m_count - 4'd1;
        end
      end else begin
        m_ovf = 1'b0;
      end
      tick();
      expect_state("rand", m_count, m_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
